alu_op_scheduler: RTL and testbench

ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

---
 rtl/alu_op_scheduler_pkg.sv | 27 ++
 rtl/alu_op_scheduler_arbiter.sv | 46 ++++
 rtl/alu_op_scheduler.sv | 155 +++++++++++++++
 tb/tb_alu_op_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_scheduler_pkg.sv
// Shared constants for the ALU operation scheduler: opcodes, per-op latencies
// and the scheduler FSM state encoding.
package alu_op_scheduler_pkg;

    localparam int OP_ADD   = 0;
    localparam int OP_SUB   = 1;
    localparam int OP_MUL   = 2;
    localparam int OP_DIV   = 3;
    localparam int OP_FPADD = 4;

    // Cycles from alu_start to the cycle in which alu_y is sampled
    localparam int LAT_ADD   = 1;
    localparam int LAT_SUB   = 1;
    localparam int LAT_MUL   = 32;
    localparam int LAT_DIV   = 32;
    localparam int LAT_FPADD = 32;

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/alu_op_scheduler_arbiter.sv
// Two-requester grant logic for the ALU operation scheduler.
// ALU_OP_SCHEDULER_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module alu_op_arbiter (
`ifdef ALU_OP_SCHEDULER_RR_EN
    input  logic       clk,
    input  logic       rst_n,
    input  logic       gnt_take,
`endif
    input  logic [1:0] req,
    output logic       gnt_vld,
    output logic       gnt_idx
);

`ifdef ALU_OP_SCHEDULER_RR_EN
    // ptr_q names the requester that wins a tie; it flips away from each winner
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_vld = |req;
        if (req == 2'b11) begin
            gnt_idx = ptr_q;
        end else begin
            gnt_idx = ~req[0];
        end
        ptr_d = ptr_q;
        if (gnt_take) begin
            ptr_d = ~gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt_vld = |req;
        gnt_idx = ~req[0];
    end
`endif

endmodule

// File: rtl/alu_op_scheduler.sv
// Serialises two requesters onto one external ALU datapath and returns results.
// Build option: ALU_OP_SCHEDULER_RR_EN enables round-robin arbitration.
module alu_op_scheduler
    import alu_op_scheduler_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SR_W   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*SR_W-1:0]   req_sr,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [SR_W-1:0]     alu_sr,
    output logic                alu_start,
    input  logic [DATA_W-1:0]   alu_y
);

    function automatic logic [CNT_W-1:0] op_latency(input logic [SR_W-1:0] op);
        logic [CNT_W-1:0] lat;
        case (op)
            SR_W'(OP_ADD):   lat = CNT_W'(LAT_ADD);
            SR_W'(OP_SUB):   lat = CNT_W'(LAT_SUB);
            SR_W'(OP_MUL):   lat = CNT_W'(LAT_MUL);
            SR_W'(OP_DIV):   lat = CNT_W'(LAT_DIV);
            SR_W'(OP_FPADD): lat = CNT_W'(LAT_FPADD);
            default:         lat = '0;
        endcase
        return lat;
    endfunction

    function automatic logic op_supported(input logic [SR_W-1:0] op);
        return op <= SR_W'(OP_FPADD);
    endfunction

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sel_q, sel_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                err_q, err_d;

    logic                gnt_vld;
    logic                gnt_idx;
    logic                gnt_take;
    logic [SR_W-1:0]     gnt_sr;

    alu_op_arbiter u_arbiter (
`ifdef ALU_OP_SCHEDULER_RR_EN
        .clk      (clk),
        .rst_n    (rst_n),
        .gnt_take (gnt_take),
`endif
        .req      (req_valid),
        .gnt_vld  (gnt_vld),
        .gnt_idx  (gnt_idx)
    );

    assign gnt_sr = gnt_idx ? req_sr[SR_W +: SR_W] : req_sr[0 +: SR_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        sr_d      = sr_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        err_d     = err_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        alu_start = 1'b0;
        gnt_take  = 1'b0;

        case (state_q)
            IDLE: begin
                // Gated by rst_n so no grant is advertised while reset is held
                if (gnt_vld && rst_n) begin
                    gnt_take           = 1'b1;
                    req_ready[gnt_idx] = 1'b1;
                    sel_d              = gnt_idx;
                    sr_d               = gnt_sr;
                    a_d                = gnt_idx ? req_a[DATA_W +: DATA_W] : req_a[0 +: DATA_W];
                    b_d                = gnt_idx ? req_b[DATA_W +: DATA_W] : req_b[0 +: DATA_W];
                    if (op_supported(gnt_sr)) begin
                        state_d = ISSUE;
                    end else begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                alu_start = 1'b1;
                cnt_d     = op_latency(sr_q);
                state_d   = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res_d   = alu_y;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid[sel_q] = 1'b1;
                if (rsp_ready[sel_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            sr_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            sr_q    <= sr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_sr   = sr_q;
    assign rsp_data = res_q;
    assign rsp_err  = err_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed testbench for alu_op_scheduler with a latency-exact ALU model.
module tb_alu_op_scheduler;

    localparam int DATA_W = 32;
    localparam int SR_W   = 6;

    logic                clk;
    logic                rst_n;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*SR_W-1:0]   req_sr;
    logic [2*DATA_W-1:0] req_a;
    logic [2*DATA_W-1:0] req_b;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [SR_W-1:0]     alu_sr;
    logic                alu_start;
    logic [DATA_W-1:0]   alu_y;

    int errors  = 0;
    int checks  = 0;
    int n_start = 0;

    alu_op_scheduler #(.DATA_W(DATA_W), .SR_W(SR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sr    (req_sr),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sr    (alu_sr),
        .alu_start (alu_start),
        .alu_y     (alu_y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ALU model: result is valid only in the cycle exactly 'latency' after alu_start
    logic [DATA_W-1:0] m_a, m_b;
    logic [SR_W-1:0]   m_sr;
    int                m_cnt = 0;

    always @(posedge clk) begin
        if (alu_start) begin
            m_a   <= alu_a;
            m_b   <= alu_b;
            m_sr  <= alu_sr;
            m_cnt <= 1;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt + 1;
        end
        if (rst_n && alu_start) n_start <= n_start + 1;
    end

    always_comb begin
        int lat;
        logic [DATA_W-1:0] r;
        lat = (m_sr <= 1) ? 1 : 32;
        case (m_sr)
            0:       r = m_a + m_b;
            1:       r = m_a - m_b;
            2:       r = m_a * m_b;
            3:       r = (m_b != 0) ? m_a / m_b : '0;
            default: r = m_a + m_b;
        endcase
        alu_y = (m_cnt == lat) ? r : 32'hDEAD_BEEF;
    end

    task automatic set_req(input int i, input int sr, input int a, input int b);
        req_sr[i*SR_W +: SR_W]       = SR_W'(sr);
        req_a[i*DATA_W +: DATA_W]    = DATA_W'(a);
        req_b[i*DATA_W +: DATA_W]    = DATA_W'(b);
        req_valid[i]                 = 1'b1;
    endtask

    // Returns at the negedge following the grant edge
    task automatic wait_grant(output int g, output logic [1:0] rr, output bit to);
        to = 1'b1;
        g  = -1;
        rr = 2'b00;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (req_ready != 2'b00) begin
                rr = req_ready;
                g  = req_ready[1] ? 1 : 0;
                to = 1'b0;
                @(posedge clk);
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output logic [1:0] v, output int cyc, output bit held, output bit to);
        logic [DATA_W-1:0] a0, b0;
        logic [SR_W-1:0]   s0;
        a0 = alu_a; b0 = alu_b; s0 = alu_sr;
        to = 1'b1; held = 1'b1; cyc = 0; v = 2'b00;
        for (int i = 0; i < 80; i++) begin
            #1;
            if (rsp_valid != 2'b00) begin
                v  = rsp_valid;
                to = 1'b0;
                break;
            end
            if (alu_a !== a0 || alu_b !== b0 || alu_sr !== s0) held = 1'b0;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic accept(input logic [1:0] bits);
        rsp_ready = bits;
        @(negedge clk);
        rsp_ready = 2'b00;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        req_sr = '0; req_a = '0; req_b = '0;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b want=00", rsp_valid); end
        checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got=%0h want=0", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
        checks++; if (alu_start !== 1'b0) begin errors++; $display("FAIL reset_alu_start got=%b want=0", alu_start); end
        checks++; if (alu_a !== '0 || alu_b !== '0 || alu_sr !== '0) begin
            errors++; $display("FAIL reset_alu_ops got=%0h/%0h/%0h want=0/0/0", alu_a, alu_b, alu_sr);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add;
        int g, cyc, s0; logic [1:0] rr, v; bit to, held;
        s0 = n_start;
        set_req(0, 0, 5, 7);
        wait_grant(g, rr, to);
        req_valid = 2'b00;
        checks++; if (to || rr !== 2'b01) begin errors++; $display("FAIL add_grant got=%b want=01", rr); end
        checks++; if (alu_start !== 1'b1 || alu_a !== 5 || alu_b !== 7 || alu_sr !== 0) begin
            errors++; $display("FAIL add_issue got start=%b a=%0d b=%0d sr=%0d want 1/5/7/0", alu_start, alu_a, alu_b, alu_sr);
        end
        wait_rsp(v, cyc, held, to);
        checks++; if (to || v !== 2'b01) begin errors++; $display("FAIL add_rsp_valid got=%b want=01", v); end
        checks++; if (rsp_data !== 12 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL add_rsp got data=%0d err=%b want 12/0", rsp_data, rsp_err);
        end
        checks++; if (cyc != 2) begin errors++; $display("FAIL add_latency got=%0d want=2", cyc); end
        checks++; if (n_start - s0 != 1) begin errors++; $display("FAIL add_start_count got=%0d want=1", n_start - s0); end
        accept(2'b01);
        #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL add_after_accept got=%b want=00", rsp_valid); end
    endtask

    task automatic test_mul;
        int g, cyc; logic [1:0] rr, v; bit to, held;
        set_req(1, 2, 3, 4);
        wait_grant(g, rr, to);
        req_valid = 2'b00;
        req_a = '1; req_b = '1; req_sr = '1;
        checks++; if (to || g != 1) begin errors++; $display("FAIL mul_grant got=%0d want=1", g); end
        wait_rsp(v, cyc, held, to);
        checks++; if (to || v !== 2'b10) begin errors++; $display("FAIL mul_rsp_valid got=%b want=10", v); end
        checks++; if (rsp_data !== 12 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL mul_rsp got data=%0d err=%b want 12/0", rsp_data, rsp_err);
        end
        checks++; if (cyc != 33) begin errors++; $display("FAIL mul_latency got=%0d want=33", cyc); end
        checks++; if (!held) begin errors++; $display("FAIL mul_ops_held got=0 want=1"); end
        accept(2'b10);
    endtask

    task automatic test_err;
        int g, cyc, s0; logic [1:0] rr, v; bit to, held;
        s0 = n_start;
        set_req(0, 9, 11, 22);
        wait_grant(g, rr, to);
        req_valid = 2'b00;
        checks++; if (to || g != 0) begin errors++; $display("FAIL err_grant got=%0d want=0", g); end
        wait_rsp(v, cyc, held, to);
        checks++; if (to || v !== 2'b01 || cyc != 0) begin
            errors++; $display("FAIL err_rsp_valid got=%b after %0d want=01 after 0", v, cyc);
        end
        checks++; if (rsp_err !== 1'b1 || rsp_data !== 0) begin
            errors++; $display("FAIL err_rsp got err=%b data=%0d want 1/0", rsp_err, rsp_data);
        end
        checks++; if (n_start != s0) begin errors++; $display("FAIL err_no_start got=%0d want=0", n_start - s0); end
        accept(2'b01);
    endtask

    task automatic test_stall;
        int g, cyc, s0; logic [1:0] rr, v; bit to, held, stable;
        set_req(0, 1, 20, 8);
        wait_grant(g, rr, to);
        req_valid = 2'b00;
        wait_rsp(v, cyc, held, to);
        checks++; if (to || v !== 2'b01 || rsp_data !== 12) begin
            errors++; $display("FAIL stall_rsp got v=%b data=%0d want 01/12", v, rsp_data);
        end
        set_req(1, 0, 1, 1);
        rsp_ready = 2'b10;
        s0 = n_start;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (rsp_data !== 12 || req_ready !== 2'b00 || rsp_valid !== 2'b01 || rsp_err !== 1'b0) stable = 1'b0;
            @(negedge clk);
        end
        checks++; if (!stable) begin errors++; $display("FAIL stall_hold got=0 want=1"); end
        checks++; if (n_start != s0) begin errors++; $display("FAIL stall_no_start got=%0d want=0", n_start - s0); end
        rsp_ready = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL accept_cycle_ready got=%b want=00", req_ready); end
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL next_idle_ready got=%b want=10", req_ready); end
        wait_grant(g, rr, to);
        req_valid = 2'b00;
        wait_rsp(v, cyc, held, to);
        checks++; if (to || v !== 2'b10 || rsp_data !== 2) begin
            errors++; $display("FAIL b2b_rsp got v=%b data=%0d want 10/2", v, rsp_data);
        end
        accept(2'b10);
    endtask

    task automatic test_arbitration;
        int g, cyc, exp_g; logic [1:0] rr, v; bit to, held;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_req(0, 0, 1, 2);
        set_req(1, 0, 10, 20);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_OP_SCHEDULER_RR_EN
            exp_g = i % 2;
`else
            exp_g = 0;
`endif
            wait_grant(g, rr, to);
            checks++; if (to || g != exp_g) begin errors++; $display("FAIL arb_grant%0d got=%0d want=%0d", i, g, exp_g); end
            wait_rsp(v, cyc, held, to);
            checks++; if (to || rsp_data !== (g == 1 ? 30 : 3)) begin
                errors++; $display("FAIL arb_data%0d got=%0d want=%0d", i, rsp_data, (g == 1 ? 30 : 3));
            end
            accept(v);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_abort;
        int g, cyc, s0; logic [1:0] rr, v; bit to, held, quiet;
        set_req(0, 3, 100, 5);
        wait_grant(g, rr, to);
        for (int i = 0; i < 5; i++) @(negedge clk);
        req_valid = 2'b01;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || alu_start !== 1'b0) begin
            errors++; $display("FAIL abort_ctrl got ready=%b valid=%b start=%b want 00/00/0", req_ready, rsp_valid, alu_start);
        end
        checks++; if (alu_a !== '0 || alu_b !== '0 || alu_sr !== '0 || rsp_data !== '0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL abort_data got a=%0d b=%0d sr=%0d d=%0d e=%b want zeros", alu_a, alu_b, alu_sr, rsp_data, rsp_err);
        end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        s0 = n_start;
        quiet = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid !== 2'b00 || alu_start !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet || n_start != s0) begin errors++; $display("FAIL abort_no_rsp got quiet=%b starts=%0d want 1/0", quiet, n_start - s0); end
        set_req(1, 0, 40, 2);
        wait_grant(g, rr, to);
        req_valid = 2'b00;
        wait_rsp(v, cyc, held, to);
        checks++; if (to || v !== 2'b10 || rsp_data !== 42) begin
            errors++; $display("FAIL post_reset_op got v=%b data=%0d want 10/42", v, rsp_data);
        end
        accept(2'b10);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00; rsp_ready = 2'b00;
        req_sr = '0; req_a = '0; req_b = '0;
        test_reset;
        test_add;
        test_mul;
        test_err;
        test_stall;
        test_arbitration;
        test_abort;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
